// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: five-step microcoded controller for the 8-bit bus datapath,
// decoding the IR opcode and flags into load / output-enable / subtract strobes.
module sap_control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       cf,
    input  logic       zf,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ram_load,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_load,
    output logic       halted,
    output logic [2:0] step
);
    typedef enum logic {RUN, HALT} mode_t;
    mode_t      mode, mode_n;
    logic [2:0] step_n;
    logic [3:0] op;
    logic       unused_operand;
    assign op = instr[7:4];
    assign unused_operand = ^instr[3:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= 3'd0;
            mode <= RUN;
        end else begin
            step <= step_n;
            mode <= mode_n;
        end
    end
    always_comb begin
        mode_n   = (mode == RUN && step == 3'd2 && op == 4'hF) ? HALT : mode;
        step_n   = (mode_n == HALT) ? 3'd2 : (step >= 3'd4 ? 3'd0 : step + 3'd1);
        halted   = mode == HALT && !rst;
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ram_load = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        // strobes exist only in run mode and are suppressed while reset is held
        if (!rst && mode == RUN) begin
            case (step)
                3'd0: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                3'd1: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                3'd2: case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                    end
                    4'h5: begin
                        ir_out = 1'b1;
                        a_load = 1'b1;
                    end
                    4'h6: begin
                        ir_out  = 1'b1;
                        pc_load = 1'b1;
                    end
                    4'h7: begin
                        ir_out  = 1'b1;
                        pc_load = cf;
                    end
                    4'h8: begin
                        ir_out  = 1'b1;
                        pc_load = zf;
                    end
                    4'hE: begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                    end
                    default: ;
                endcase
                3'd3: case (op)
                    4'h1: begin
                        ram_out = 1'b1;
                        a_load  = 1'b1;
                    end
                    4'h2, 4'h3: begin
                        ram_out = 1'b1;
                        b_load  = 1'b1;
                    end
                    4'h4: begin
                        a_out    = 1'b1;
                        ram_load = 1'b1;
                    end
                    default: ;
                endcase
                3'd4: if (op == 4'h2 || op == 4'h3) begin
                    alu_out = 1'b1;
                    a_load  = 1'b1;
                    alu_sub = op == 4'h3;
                end
                default: ;
            endcase
        end
    end
endmodule
